// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the I-cache refill bridge and the interconnect.
// Master modport belongs to the bridge; slave modport belongs to the interconnect or a bus model.
interface icache_axi_rd_bridge_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns single-cycle I-cache line refill requests into one AXI4 INCR read burst each.
// Optional R-channel checking (sticky err) is enabled by defining ICACHE_AXI_RCHK_EN.
module icache_axi_rd_bridge #(
    parameter logic [3:0]  AXI_ID = 4'd0,
    parameter int unsigned BEATS  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rd_req,
    input  logic [31:0]                   rd_addr,
    output logic                          rd_rdy,
    output logic                          ret_valid,
    output logic                          ret_last,
    output logic [63:0]                   ret_data,
    icache_axi_rd_bridge_if.master        axi_io,
    output logic                          err
);

    localparam logic [3:0] LastBeat = 4'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ret_valid_q, ret_valid_d;
    logic        ret_last_q, ret_last_d;
    logic [63:0] ret_data_q, ret_data_d;
    logic        beat;
    logic        last_beat;

    assign beat      = (state_q == StR) && axi_io.rvalid;
    assign last_beat = (cnt_q == LastBeat);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        ret_data_d  = ret_data_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    addr_d  = {rd_addr[31:4], 4'b0000};
                    cnt_d   = 4'd0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (axi_io.arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (beat) begin
                    ret_valid_d = 1'b1;
                    ret_data_d  = axi_io.rdata;
                    // Line end comes from our own count; rlast is only cross-checked.
                    if (last_beat) begin
                        ret_last_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= 32'd0;
            cnt_q       <= 4'd0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            ret_data_q  <= ret_data_d;
        end
    end

    assign rd_rdy         = (state_q == StIdle);
    assign ret_valid      = ret_valid_q;
    assign ret_last       = ret_last_q;
    assign ret_data       = ret_data_q;

    assign axi_io.arvalid = (state_q == StAr);
    assign axi_io.araddr  = addr_q;
    assign axi_io.arid    = AXI_ID;
    assign axi_io.arlen   = 8'(BEATS - 1);
    assign axi_io.arsize  = 3'b011;
    assign axi_io.arburst = 2'b01;
    assign axi_io.rready  = (state_q == StR);

`ifdef ICACHE_AXI_RCHK_EN
    logic err_q, err_d;
    logic unused_addr;

    assign unused_addr = ^rd_addr[3:0];

    always_comb begin
        err_d = err_q;
        if (beat && ((axi_io.rresp != 2'b00) || (axi_io.rid != AXI_ID) ||
                     (axi_io.rlast != last_beat))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_rchk;

    assign unused_rchk = ^{axi_io.rresp, axi_io.rid, axi_io.rlast, rd_addr[3:0]};
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed plus randomized bench for icache_axi_rd_bridge with a bus-level slave and a
// queue-based expectation model; err expectations follow ICACHE_AXI_RCHK_EN.
module tb_icache_axi_rd_bridge;

    localparam int         Beats = 2;
    localparam logic [3:0] AxiId = 4'd0;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [63:0] ret_data;
    logic        err;

    icache_axi_rd_bridge_if axi ();

    icache_axi_rd_bridge #(
        .AXI_ID (AxiId),
        .BEATS  (Beats)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .axi_io    (axi.master),
        .err       (err)
    );

    always #5 clock = ~clock;

    int          tests   = 0;
    int          fails   = 0;
    int          cyc     = 0;
    logic        err_exp = 1'b0;
    logic [63:0] exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            axi.rvalid = 1'($urandom_range(0, 1));
            axi.rdata  = {$urandom, $urandom};
            tick();
            chk("idle_rd_rdy", rd_rdy, 1);
            chk("idle_rready", axi.rready, 0);
            chk("idle_ret_valid", ret_valid, 0);
            chk("idle_arvalid", axi.arvalid, 0);
        end
        axi.rvalid = 1'b0;
    endtask

    // gap < 0: random 0..2 idle cycles before every beat; otherwise fixed gap between beats.
    task automatic do_req(input logic [31:0] addr, input int ar_wait, input int gap,
                          input int err_beat, input bit pattern);
        int          start;
        int          gap_sum;
        int          g;
        logic [31:0] exp_addr;
        logic [63:0] d;
        exp_addr = addr & 32'hFFFF_FFF0;
        gap_sum  = 0;
        start    = cyc;
        rd_req   = 1'b1;
        rd_addr  = addr;
        tick();
        rd_req  = 1'b0;
        rd_addr = $urandom;
        chk("ar_arvalid", axi.arvalid, 1);
        chk("ar_araddr", axi.araddr, exp_addr);
        chk("ar_rd_rdy", rd_rdy, 0);
        for (int i = 0; i < ar_wait; i++) begin
            axi.arready = 1'b0;
            axi.rvalid  = 1'($urandom_range(0, 1));
            tick();
            chk("arwait_arvalid", axi.arvalid, 1);
            chk("arwait_araddr", axi.araddr, exp_addr);
            chk("arwait_rready", axi.rready, 0);
            chk("arwait_ret_valid", ret_valid, 0);
        end
        axi.rvalid  = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("r_rready", axi.rready, 1);
        chk("r_arvalid", axi.arvalid, 0);
        for (int b = 0; b < Beats; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((b == 0) ? 0 : gap);
            gap_sum += g;
            for (int i = 0; i < g; i++) begin
                tick();
                chk("gap_ret_valid", ret_valid, 0);
                chk("gap_ret_last", ret_last, 0);
                chk("gap_rd_rdy", rd_rdy, 0);
                chk("gap_rready", axi.rready, 1);
            end
            d = pattern ? 64'h1111_1111_1111_1111 * 64'(b + 1) : {$urandom, $urandom};
            exp_q.push_back(d);
            axi.rvalid = 1'b1;
            axi.rdata  = d;
            axi.rlast  = (b == Beats - 1);
            axi.rid    = AxiId;
            axi.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
`ifdef ICACHE_AXI_RCHK_EN
            if (b == err_beat) err_exp = 1'b1;
`endif
            tick();
            axi.rvalid = 1'b0;
            axi.rresp  = 2'b00;
            axi.rlast  = 1'b0;
            chk("beat_ret_valid", ret_valid, 1);
            chk("beat_ret_data", ret_data, exp_q.pop_front());
            chk("beat_ret_last", ret_last, (b == Beats - 1));
            chk("beat_rd_rdy", rd_rdy, (b == Beats - 1));
            chk("beat_err", err, err_exp);
        end
        chk("latency", 64'(cyc - start), 64'(2 + ar_wait + gap_sum + Beats));
    endtask

    initial begin
        reset       = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = 32'd0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 64'd0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rid     = 4'd0;
        tick();
        tick();
        chk("rst_rd_rdy", rd_rdy, 1);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_araddr", axi.araddr, 0);
        chk("rst_ret_valid", ret_valid, 0);
        chk("rst_ret_last", ret_last, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_err", err, 0);
        chk("const_arid", axi.arid, AxiId);
        chk("const_arlen", axi.arlen, Beats - 1);
        chk("const_arsize", axi.arsize, 3'b011);
        chk("const_arburst", axi.arburst, 2'b01);
        reset = 1'b0;
        idle(2);

        // Zero-wait line with known data: ret_last lands four cycles after rd_req.
        do_req(32'h8000_0124, 0, 0, -1, 1'b1);
        idle(1);
        // Slow arready, then slow R beats.
        do_req(32'h1234_567F, 5, 0, -1, 1'b0);
        idle(1);
        do_req(32'h0000_ABC8, 0, 3, -1, 1'b0);
        // Back-to-back: second request driven in the ret_last cycle.
        do_req(32'hCAFE_0010, 0, 0, -1, 1'b0);
        do_req(32'hDEAD_BEEF, 1, 1, -1, 1'b0);
        idle(2);

        // Reset while in R after the first beat.
        rd_req  = 1'b1;
        rd_addr = 32'h4000_0040;
        tick();
        rd_req      = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 64'h0123_4567_89AB_CDEF;
        tick();
        axi.rvalid = 1'b0;
        chk("pre_rst_ret_valid", ret_valid, 1);
        reset = 1'b1;
        tick();
        chk("midrst_rd_rdy", rd_rdy, 1);
        chk("midrst_rready", axi.rready, 0);
        chk("midrst_arvalid", axi.arvalid, 0);
        chk("midrst_ret_valid", ret_valid, 0);
        chk("midrst_err", err, 0);
        reset   = 1'b0;
        err_exp = 1'b0;
        idle(2);

        // Erroring beat 1: data still returned, err sticky until reset.
        do_req(32'h9000_0100, 0, 0, 1, 1'b1);
        idle(3);
        chk("err_sticky", err, err_exp);
        do_req(32'h9000_0200, 0, 1, -1, 1'b0);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        err_exp = 1'b0;
        chk("err_cleared", err, 0);
        idle(1);

        for (int n = 0; n < 25; n++) begin
            do_req($urandom, int'($urandom_range(0, 3)), -1,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, Beats - 1)) : -1,
                   1'b0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
